// File: rtl/pmod_cls_line_streamer.sv
// Expands two latched 16-char lines into the Pmod CLS escape stream and sequences
// the clear and text SPI transactions through the driver's TX FIFO.
module pmod_cls_line_streamer #(
    parameter int c_tx_len_bits       = 11,
    parameter int c_rx_len_bits       = 11,
    parameter int c_clear_wait_clocks = 100000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_update_req,
    input  logic [127:0]             i_line_top,
    input  logic [127:0]             i_line_bot,
    output logic                     o_ready,
    output logic                     o_done,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_spi_go,
    output logic [c_tx_len_bits-1:0] o_tx_len,
    output logic [1:0]               o_wait_cyc,
    output logic [c_rx_len_bits-1:0] o_rx_len,
    input  logic                     i_spi_idle
);

    localparam int c_cnt_bits = (c_clear_wait_clocks > 1) ? $clog2(c_clear_wait_clocks) : 1;
    localparam logic [c_cnt_bits-1:0] c_delay_init = c_cnt_bits'(c_clear_wait_clocks - 1);

    localparam logic [0:2][7:0] c_clr_seq = {8'h1B, 8'h5B, 8'h6A};
    localparam logic [0:5][7:0] c_pos_top = {8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h48};
    localparam logic [0:5][7:0] c_pos_bot = {8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h48};

    typedef enum logic [3:0] {
        IDLE,
        CLR_LOAD,
        CLR_GO,
        CLR_WAIT,
        CLR_DELAY,
        TXT_LOAD,
        TXT_GO,
        TXT_WAIT,
        DONE
    } state_t;

    state_t                 state;
    logic [5:0]             idx;
    logic [c_cnt_bits-1:0]  dly;
    logic                   seen_busy;
    // Ascending packed range so element k is character k (MSB byte first).
    logic [0:15][7:0]       top_l;
    logic [0:15][7:0]       bot_l;

    logic [5:0] off_top;
    logic [5:0] off_hdr;
    logic [5:0] off_bot;
    logic [7:0] tx_byte;

    always_comb begin
        tx_byte = 8'h00;
        off_top = idx - 6'd6;
        off_hdr = idx - 6'd22;
        off_bot = idx - 6'd28;
        case (state)
            CLR_LOAD: tx_byte = c_clr_seq[idx[1:0]];
            TXT_LOAD: begin
                if (idx < 6'd6)       tx_byte = c_pos_top[idx[2:0]];
                else if (idx < 6'd22) tx_byte = top_l[off_top[3:0]];
                else if (idx < 6'd28) tx_byte = c_pos_bot[off_hdr[2:0]];
                else                  tx_byte = bot_l[off_bot[3:0]];
            end
            default: tx_byte = 8'h00;
        endcase
    end

    assign o_tx_data  = tx_byte;
    assign o_tx_valid = (state == CLR_LOAD) || (state == TXT_LOAD);
    // Launch is immediate on the cycle the driver reports idle so go is exactly one cycle.
    assign o_spi_go   = ((state == CLR_GO) || (state == TXT_GO)) && i_spi_idle;
    assign o_ready    = (state == IDLE);
    assign o_done     = (state == DONE);
    assign o_wait_cyc = 2'd0;
    assign o_rx_len   = '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            dly       <= '0;
            seen_busy <= 1'b0;
            top_l     <= '0;
            bot_l     <= '0;
            o_tx_len  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_update_req) begin
                        top_l <= i_line_top;
                        bot_l <= i_line_bot;
                        idx   <= '0;
                        state <= CLR_LOAD;
                    end
                end
                CLR_LOAD: begin
                    if (i_tx_ready) begin
                        if (idx == 6'd2) begin
                            idx      <= '0;
                            o_tx_len <= c_tx_len_bits'(3);
                            state    <= CLR_GO;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                CLR_GO: begin
                    seen_busy <= 1'b0;
                    if (i_spi_idle) state <= CLR_WAIT;
                end
                CLR_WAIT: begin
                    // Driver may still look idle right after go; require busy before idle.
                    if (!seen_busy) begin
                        if (!i_spi_idle) seen_busy <= 1'b1;
                    end else if (i_spi_idle) begin
                        seen_busy <= 1'b0;
                        dly       <= c_delay_init;
                        state     <= CLR_DELAY;
                    end
                end
                CLR_DELAY: begin
                    if (dly == '0) begin
                        idx   <= '0;
                        state <= TXT_LOAD;
                    end else begin
                        dly <= dly - 1'b1;
                    end
                end
                TXT_LOAD: begin
                    if (i_tx_ready) begin
                        if (idx == 6'd43) begin
                            idx      <= '0;
                            o_tx_len <= c_tx_len_bits'(44);
                            state    <= TXT_GO;
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                TXT_GO: begin
                    seen_busy <= 1'b0;
                    if (i_spi_idle) state <= TXT_WAIT;
                end
                TXT_WAIT: begin
                    if (!seen_busy) begin
                        if (!i_spi_idle) seen_busy <= 1'b1;
                    end else if (i_spi_idle) begin
                        seen_busy <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmod_cls_line_streamer.sv
// Directed bench: FIFO capture, SPI driver model, backpressure, busy-at-go,
// clear delay, dropped request and mid-stream reset.
module tb_pmod_cls_line_streamer;

    localparam int c_delay = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         update_req = 1'b0;
    logic [127:0] line_top = '0;
    logic [127:0] line_bot = '0;
    logic         ready;
    logic         done;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         spi_go;
    logic [10:0]  tx_len;
    logic [1:0]   wait_cyc;
    logic [10:0]  rx_len;
    logic         spi_idle;

    pmod_cls_line_streamer #(
        .c_tx_len_bits(11), .c_rx_len_bits(11), .c_clear_wait_clocks(c_delay)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_update_req(update_req),
        .i_line_top(line_top), .i_line_bot(line_bot),
        .o_ready(ready), .o_done(done), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_spi_go(spi_go), .o_tx_len(tx_len),
        .o_wait_cyc(wait_cyc), .o_rx_len(rx_len), .i_spi_idle(spi_idle)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    endtask

    // SPI driver model: idle 1 cycle after go, busy 20 cycles, then idle.
    int   spi_cnt = 0;
    logic go_seen = 1'b0;
    logic hold = 1'b0;
    logic bp = 1'b0;
    assign spi_idle = !hold && !(spi_cnt >= 1 && spi_cnt <= 20);

    always @(posedge clk) begin
        if (!rst_n)       spi_cnt <= 0;
        else if (go_seen) spi_cnt <= 21;
        else if (spi_cnt > 0) spi_cnt <= spi_cnt - 1;
    end

    always @(posedge clk) begin
        #1;
        tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [7:0]  cap[$];
    logic [7:0]  exp_q[$];
    logic [10:0] lens[$];
    int   go_cnt, done_cnt, cyc, x_cyc, y_cyc;
    logic mb, stall_pend;
    logic [7:0] stall_data;

    initial begin
        go_cnt = 0; done_cnt = 0; cyc = 0; x_cyc = -1; y_cyc = -1;
        mb = 1'b0; stall_pend = 1'b0; stall_data = 8'h00;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_pend = 1'b0;
            go_seen    = 1'b0;
        end else begin
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            if (stall_pend && tx_valid) chk("stall_hold", 32'(tx_data), 32'(stall_data));
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;
            go_seen = spi_go;
            if (spi_go) begin go_cnt++; lens.push_back(tx_len); end
            if (done) done_cnt++;
            if (go_cnt == 1 && !spi_idle) mb = 1'b1;
            if (go_cnt == 1 && mb && spi_idle && x_cyc < 0) x_cyc = cyc;
            if (go_cnt == 1 && tx_valid && y_cyc < 0) y_cyc = cyc;
        end
    end

    task automatic build_exp(input logic [127:0] t, input logic [127:0] b);
        logic [7:0] h0 [6] = '{8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h48};
        logic [7:0] h1 [6] = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h30, 8'h48};
        exp_q.delete();
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h6A);
        for (int i = 0; i < 6; i++)  exp_q.push_back(h0[i]);
        for (int i = 0; i < 16; i++) exp_q.push_back(t[127-8*i -: 8]);
        for (int i = 0; i < 6; i++)  exp_q.push_back(h1[i]);
        for (int i = 0; i < 16; i++) exp_q.push_back(b[127-8*i -: 8]);
    endtask

    task automatic start_req(input logic [127:0] t, input logic [127:0] b);
        cap.delete(); lens.delete();
        go_cnt = 0; done_cnt = 0; x_cyc = -1; y_cyc = -1; mb = 1'b0;
        build_exp(t, b);
        @(posedge clk); #1;
        line_top = t; line_bot = b; update_req = 1'b1;
        @(posedge clk); #1;
        update_req = 1'b0; line_top = '1; line_bot = '0;
        @(negedge clk);
        chk("first_ready", 32'(ready), 0);
        chk("first_valid", 32'(tx_valid), 1);
        chk("first_byte", 32'(tx_data), 32'h1B);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            if (done) hit = 1'b1;
        end
        chk("done_seen", 32'(hit), 1);
        if (hit) begin
            chk("ready_at_done", 32'(ready), 0);
            @(negedge clk);
            chk("ready_after_done", 32'(ready), 1);
        end
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_nbytes"}, 32'(cap.size()), 47);
        if (cap.size() == 47)
            for (int i = 0; i < 47; i++)
                chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
        chk({tag, "_gos"}, 32'(go_cnt), 2);
        if (lens.size() == 2) begin
            chk({tag, "_len0"}, 32'(lens[0]), 3);
            chk({tag, "_len1"}, 32'(lens[1]), 44);
        end
        chk({tag, "_dones"}, 32'(done_cnt), 1);
    endtask

    task automatic wait_bytes(input int nb, input int budget);
        int n = 0;
        while (cap.size() < nb && n < budget) begin @(negedge clk); n++; end
        chk("bytes_reached", 32'(cap.size() >= nb), 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_valid"}, 32'(tx_valid), 0);
        chk({tag, "_go"}, 32'(spi_go), 0);
        chk({tag, "_data"}, 32'(tx_data), 0);
        chk({tag, "_len"}, 32'(tx_len), 0);
        chk({tag, "_waitc"}, 32'(wait_cyc), 0);
        chk({tag, "_rxlen"}, 32'(rx_len), 0);
    endtask

    initial begin
        int vcnt;
        repeat (3) @(negedge clk);
        check_reset_outs("rst");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(ready), 1);

        // Nominal update plus clear-delay gap
        start_req("HELLO WORLD     ", "ACL2 X=+0123    ");
        wait_done(2000);
        check_seq("nom");
        chk("delay_gap", 32'(y_cyc - x_cyc - 1), c_delay);
        chk("len_hold", 32'(tx_len), 44);

        // Backpressure with a dropped request mid text load
        bp = 1'b1;
        start_req("PMOD CLS 16X2 OK", "BACKPRESSURE #2!");
        wait_bytes(13, 1000);
        @(posedge clk); #1;
        line_top = "XXXXXXXXXXXXXXXX"; update_req = 1'b1;
        @(posedge clk); #1 update_req = 1'b0;
        wait_done(3000);
        bp = 1'b0;
        repeat (80) @(negedge clk);
        check_seq("bp");
        chk("drop_ready", 32'(ready), 1);

        // SPI busy when entering CLR_GO
        hold = 1'b1;
        start_req("BUSY AT GO TEST ", "0123456789ABCDEF");
        repeat (15) @(negedge clk);
        chk("busy_nbytes", 32'(cap.size()), 3);
        chk("busy_nogo", 32'(go_cnt), 0);
        @(posedge clk); #1 hold = 1'b0;
        wait_done(2000);
        check_seq("busy");

        // Reset in the middle of TXT_LOAD
        start_req("HELLO WORLD     ", "ACL2 X=+0123    ");
        wait_bytes(20, 1000);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check_reset_outs("mid_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        vcnt = 0;
        repeat (8) begin @(negedge clk); if (tx_valid) vcnt++; end
        chk("post_rst_novalid", 32'(vcnt), 0);
        chk("post_rst_ready", 32'(ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
